// File: rtl/machine_log_scheduler.sv
// Machine log scheduler: round-robin arbiter over four log sources feeding a
// record FIFO, drained by a three-state emitter that presents each record for
// one full cycle before strobing it into the logger with a rising log_tick.
module machine_log_scheduler #(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [3:0]             req,
    input  logic [3:0]             req_status,
    input  logic [15:0]            req_p2,
    input  logic [15:0]            req_p3,
    input  logic [15:0]            req_p4,
    output logic [3:0]             ack,
    output logic                   log_tick,
    output logic [1:0]             log_operator,
    output logic                   log_param1,
    output logic [3:0]             log_param2,
    output logic [3:0]             log_param3,
    output logic [3:0]             log_param4,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = 15;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PRESENT = 2'd1;
    localparam logic [1:0] STROBE  = 2'd2;

    // Record layout: {operator[1:0], status, p2[3:0], p3[3:0], p4[3:0]}
    logic [RW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [1:0]    state;
    logic [1:0]    last_grant;
    logic [1:0]    grant_idx;
    logic [1:0]    candidate;
    logic [3:0]    eligible;
    logic          grant_valid;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [RW-1:0] wr_record;
    logic [RW-1:0] head_record;

    // FIFO status, push/pop decisions and the record assembled for the grantee
    always_comb begin
        fifo_full   = (fifo_count == CW'(DEPTH));
        fifo_empty  = (fifo_count == '0);
        eligible    = req & ~ack;
        push        = grant_valid && !fifo_full;
        pop         = !fifo_empty && ((state == IDLE) || (state == STROBE));
        wr_record   = {grant_idx,
                       req_status[grant_idx],
                       req_p2[{grant_idx, 2'b00} +: 4],
                       req_p3[{grant_idx, 2'b00} +: 4],
                       req_p4[{grant_idx, 2'b00} +: 4]};
        head_record = mem[rd_ptr];
        busy        = !fifo_empty || (state != IDLE);
    end

    // Round-robin search starting just after the previously granted source
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = last_grant;
        candidate   = last_grant;
        for (int k = 1; k <= 4; k++) begin
            candidate = last_grant + 2'(k);
            if (!grant_valid && eligible[candidate]) begin
                grant_valid = 1'b1;
                grant_idx   = candidate;
            end
        end
    end

    // Record storage; pointers alone define validity so no reset is needed here
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wr_record;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Accept pulse for the granted source and round-robin history
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ack        <= 4'b0000;
            last_grant <= 2'd3;
        end else begin
            ack <= push ? (4'b0001 << grant_idx) : 4'b0000;
            if (push) begin
                last_grant <= grant_idx;
            end
        end
    end

    // Emitter: load record on PRESENT entry, raise log_tick in STROBE, then reload or idle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            log_tick     <= 1'b0;
            log_operator <= 2'd0;
            log_param1   <= 1'b0;
            log_param2   <= 4'd0;
            log_param3   <= 4'd0;
            log_param4   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    log_tick <= 1'b0;
                    if (pop) begin
                        {log_operator, log_param1, log_param2, log_param3, log_param4} <= head_record;
                        state <= PRESENT;
                    end
                end
                PRESENT: begin
                    log_tick <= 1'b1;
                    state    <= STROBE;
                end
                STROBE: begin
                    log_tick <= 1'b0;
                    if (pop) begin
                        {log_operator, log_param1, log_param2, log_param3, log_param4} <= head_record;
                        state <= PRESENT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    log_tick <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_machine_log_scheduler.sv
// Testbench for machine_log_scheduler: table of single-source records plus
// hand-written sequences for ordering, saturation, spacing, fairness and reset.
`timescale 1ns/1ps
module tb_machine_log_scheduler;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [1:0] op;
        logic       st;
        logic [3:0] p2;
        logic [3:0] p3;
        logic [3:0] p4;
    } rec_t;

    typedef struct {
        logic [3:0]  reqv;
        logic [3:0]  statusv;
        logic [15:0] p2v;
        logic [15:0] p3v;
        logic [15:0] p4v;
        rec_t        exp;
    } vec_t;

    logic        clock;
    logic        reset_n;
    logic [3:0]  req;
    logic [3:0]  req_status;
    logic [15:0] req_p2;
    logic [15:0] req_p3;
    logic [15:0] req_p4;
    logic [3:0]  ack;
    logic        log_tick;
    logic [1:0]  log_operator;
    logic        log_param1;
    logic [3:0]  log_param2;
    logic [3:0]  log_param3;
    logic [3:0]  log_param4;
    logic [$clog2(DEPTH):0] fifo_count;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    rec_t tick_q[$];
    time  tick_t[$];
    int   tick_total   = 0;
    int   tick_in_reset = 0;

    vec_t vecs[6];

    machine_log_scheduler #(.DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .req(req),
        .req_status(req_status),
        .req_p2(req_p2),
        .req_p3(req_p3),
        .req_p4(req_p4),
        .ack(ack),
        .log_tick(log_tick),
        .log_operator(log_operator),
        .log_param1(log_param1),
        .log_param2(log_param2),
        .log_param3(log_param3),
        .log_param4(log_param4),
        .fifo_count(fifo_count),
        .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Capture every committed record at the logger clock edge
    always @(posedge log_tick) begin
        rec_t r;
        r = {log_operator, log_param1, log_param2, log_param3, log_param4};
        if (!reset_n) tick_in_reset++;
        tick_q.push_back(r);
        tick_t.push_back($time);
        tick_total++;
    end

    // Hard time limit so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic rec_t mkRec(input logic [1:0] op, input logic st,
                                   input logic [3:0] p2, input logic [3:0] p3,
                                   input logic [3:0] p4);
        rec_t r;
        r.op = op; r.st = st; r.p2 = p2; r.p3 = p3; r.p4 = p4;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        req = 4'b0; req_status = 4'b0;
        req_p2 = 16'h0; req_p3 = 16'h0; req_p4 = 16'h0;
    endtask

    task automatic doReset();
        @(negedge clock);
        reset_n = 1'b0;
        clearInputs();
        repeat (2) @(negedge clock);
        tick_q.delete();
        tick_t.delete();
        reset_n = 1'b1;
    endtask

    // One isolated request: grant, single-cycle ack, record content and latency
    task automatic applyStimulus(input int idx, input vec_t v);
        time grant_t;
        rec_t got;
        grant_t = 0;
        @(negedge clock);
        req = v.reqv; req_status = v.statusv;
        req_p2 = v.p2v; req_p3 = v.p3v; req_p4 = v.p4v;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (ack != 4'b0) break;
        end
        grant_t = $time - 5;
        checkOutput($sformatf("vec%0d ack", idx), 32'(ack), 32'(v.reqv));
        checkOutput($sformatf("vec%0d busy", idx), 32'(busy), 32'd1);
        req = 4'b0;
        @(negedge clock);
        checkOutput($sformatf("vec%0d ack single pulse", idx), 32'(ack), 32'd0);
        for (int c = 0; c < 10 && tick_q.size() == 0; c++) @(negedge clock);
        checkOutput($sformatf("vec%0d tick count", idx), 32'(tick_q.size()), 32'd1);
        if (tick_q.size() != 0) begin
            got = tick_q.pop_front();
            checkOutput($sformatf("vec%0d record", idx), 32'(got), 32'(v.exp));
            checkOutput($sformatf("vec%0d latency", idx), 32'(tick_t.pop_front() - grant_t), 32'd20);
        end
        repeat (2) @(negedge clock);
        checkOutput($sformatf("vec%0d idle", idx), 32'(busy), 32'd0);
    endtask

    initial begin
        logic [3:0] seqn [4];
        logic [3:0] sq;
        int   granted;
        int   ack_cnt [4];
        int   order [$];
        int   prev_count;
        int   max_count;
        int   full_seen;
        int   found;
        int   ticks_before;
        int   base_ticks;
        rec_t expA [4];

        reset_n = 1'b0;
        clearInputs();

        vecs[0] = '{4'b0001, 4'b0001, 16'h4443, 16'h5552, 16'h6669, mkRec(2'd0, 1'b1, 4'h3, 4'h2, 4'h9)};
        vecs[1] = '{4'b0010, 4'b1101, 16'h12F4, 16'h3406, 16'h7080, mkRec(2'd1, 1'b0, 4'hF, 4'h0, 4'h8)};
        vecs[2] = '{4'b0100, 4'b0100, 16'h0A00, 16'hF5FF, 16'h1F23, mkRec(2'd2, 1'b1, 4'hA, 4'h5, 4'hF)};
        vecs[3] = '{4'b1000, 4'b0111, 16'hC000, 16'h0FFF, 16'hFEEE, mkRec(2'd3, 1'b0, 4'hC, 4'h0, 4'hF)};
        vecs[4] = '{4'b1000, 4'b1000, 16'h0FFF, 16'h7000, 16'h0000, mkRec(2'd3, 1'b1, 4'h0, 4'h7, 4'h0)};
        vecs[5] = '{4'b0001, 4'b1110, 16'hFFF0, 16'h000F, 16'h5555, mkRec(2'd0, 1'b0, 4'h0, 4'hF, 4'h5)};

        // Reset state with requests pending
        req = 4'b1111;
        #12;
        checkOutput("reset ack", 32'(ack), 32'd0);
        checkOutput("reset log outputs",
                    32'({log_tick, log_operator, log_param1, log_param2, log_param3, log_param4}), 32'd0);
        checkOutput("reset fifo_count", 32'(fifo_count), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        clearInputs();
        @(negedge clock);
        reset_n = 1'b1;

        // Table-driven single requests
        for (int i = 0; i < 6; i++) applyStimulus(i, vecs[i]);

        // All four requests held from reset, each source drops after its ack
        @(negedge clock);
        reset_n = 1'b0;
        req = 4'b1111; req_status = 4'b1010;
        req_p2 = 16'h3210; req_p3 = 16'hCDEF; req_p4 = 16'h5A5A;
        repeat (2) @(negedge clock);
        tick_q.delete(); tick_t.delete();
        for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
        order.delete();
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("first grant after release", 32'(ack), 32'b0001);
        for (int c = 0; c < 30; c++) begin
            for (int i = 0; i < 4; i++) if (ack[i]) begin ack_cnt[i]++; order.push_back(i); end
            req = req & ~ack;
            @(negedge clock);
        end
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("all4 ack count src%0d", i), 32'(ack_cnt[i]), 32'd1);
            if (order.size() > i) checkOutput($sformatf("all4 grant order %0d", i), 32'(order[i]), 32'(i));
        end
        expA[0] = mkRec(2'd0, 1'b0, 4'h0, 4'hF, 4'hA);
        expA[1] = mkRec(2'd1, 1'b1, 4'h1, 4'hE, 4'h5);
        expA[2] = mkRec(2'd2, 1'b0, 4'h2, 4'hD, 4'hA);
        expA[3] = mkRec(2'd3, 1'b1, 4'h3, 4'hC, 4'h5);
        checkOutput("all4 tick count", 32'(tick_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < tick_q.size(); i++)
            checkOutput($sformatf("all4 record %0d", i), 32'(tick_q[i]), 32'(expA[i]));

        // Back-to-back re-requests from source 1
        doReset();
        granted = 0;
        req = 4'b0010; req_status = 4'b0010;
        req_p2 = 16'h0000; req_p3 = 16'h0070; req_p4 = 16'h0000;
        for (int c = 0; c < 40 && tick_q.size() < 5; c++) begin
            @(negedge clock);
            if (ack[1]) begin
                granted++;
                if (granted == 5) req = 4'b0;
                else req_p2[7:4] = 4'(granted);
            end
        end
        repeat (6) @(negedge clock);
        checkOutput("b2b tick count", 32'(tick_q.size()), 32'd5);
        for (int k = 0; k < 5 && k < tick_q.size(); k++)
            checkOutput($sformatf("b2b record %0d", k), 32'(tick_q[k]),
                        32'(mkRec(2'd1, 1'b1, 4'(k), 4'h7, 4'h0)));
        for (int k = 1; k < 5 && k < tick_t.size(); k++)
            checkOutput($sformatf("b2b spacing %0d", k), 32'(tick_t[k] - tick_t[k-1]), 32'd20);

        // Continuous requests from all sources fill the FIFO to saturation
        doReset();
        granted = 0; prev_count = 0; max_count = 0; full_seen = 0;
        for (int i = 0; i < 4; i++) seqn[i] = 4'd0;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            req_status[i] = seqn[i][0];
            req_p2[4*i +: 4] = 4'(i);
            req_p3[4*i +: 4] = seqn[i];
            req_p4[4*i +: 4] = ~seqn[i];
        end
        for (int c = 0; c < 150 && tick_q.size() < 12; c++) begin
            @(negedge clock);
            if (prev_count == DEPTH) begin
                full_seen++;
                checkOutput("fill ack while full", 32'(ack), 32'd0);
            end
            prev_count = int'(fifo_count);
            if (prev_count > max_count) max_count = prev_count;
            for (int i = 0; i < 4; i++) if (ack[i] && granted < 12) begin
                granted++;
                seqn[i] = seqn[i] + 4'd1;
                req_status[i] = seqn[i][0];
                req_p3[4*i +: 4] = seqn[i];
                req_p4[4*i +: 4] = ~seqn[i];
                if (granted == 12) req = 4'b0;
            end
        end
        checkOutput("fill max count", 32'(max_count), 32'(DEPTH));
        checkOutput("fill reached full", 32'(full_seen != 0), 32'd1);
        checkOutput("fill tick count", 32'(tick_q.size()), 32'd12);
        for (int k = 0; k < 12 && k < tick_q.size(); k++) begin
            sq = 4'(k / 4);
            checkOutput($sformatf("fill record %0d", k), 32'(tick_q[k]),
                        32'(mkRec(2'(k % 4), sq[0], 4'(k % 4), sq, ~sq)));
        end

        // Fairness between sources 0 and 2
        doReset();
        order.delete();
        req = 4'b0101; req_status = 4'b0101;
        req_p2 = 16'h0200; req_p3 = 16'h0000; req_p4 = 16'h0000;
        for (int c = 0; c < 30 && order.size() < 6; c++) begin
            @(negedge clock);
            for (int i = 0; i < 4; i++) if (ack[i]) order.push_back(i);
            if (order.size() >= 6) req = 4'b0;
        end
        for (int k = 0; k < 6; k++) begin
            if (k < order.size()) checkOutput($sformatf("rr grant %0d", k), 32'(order[k]), 32'((k % 2) * 2));
            else checkOutput($sformatf("rr grant %0d missing", k), 32'(order.size()), 32'd6);
        end
        for (int c = 0; c < 30 && tick_q.size() < 6; c++) @(negedge clock);
        checkOutput("rr tick count", 32'(tick_q.size()), 32'd6);
        for (int k = 0; k < 6 && k < tick_q.size(); k++)
            checkOutput($sformatf("rr tick op %0d", k), 32'(tick_q[k].op), 32'((k % 2) * 2));

        // Reset while strobing with three records queued
        doReset();
        found = 0;
        req = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (log_tick && fifo_count == 3) begin found = 1; break; end
        end
        checkOutput("strobe with 3 queued reached", 32'(found), 32'd1);
        base_ticks = tick_in_reset;
        reset_n = 1'b0;
        req = 4'b0;
        #1;
        checkOutput("midreset log_tick", 32'(log_tick), 32'd0);
        checkOutput("midreset fifo_count", 32'(fifo_count), 32'd0);
        checkOutput("midreset ack busy", 32'({ack, busy}), 32'd0);
        checkOutput("midreset log data",
                    32'({log_operator, log_param1, log_param2, log_param3, log_param4}), 32'd0);
        ticks_before = tick_total;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        checkOutput("post reset no ticks", 32'(tick_total - ticks_before), 32'd0);
        checkOutput("no ticks during reset", 32'(tick_in_reset - base_ticks), 32'd0);
        checkOutput("post reset idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
